// File: rtl/evm_ballot_controller.sv
// EVM session controller: round-robin booth arbiter, one-vote-per-voter tally store and sequential winner scan.
// Define EVM_REJECT_CODE_EN to add booth_reject_code (01 duplicate voter, 10 invalid candidate, 11 polls closed).
module evm_ballot_controller #(
  parameter int NUM_BOOTHS = 2,
  parameter int VOTER_W    = 4,
  parameter int CAND_W     = 4,
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          open_polls,
  input  logic                          close_polls,
  input  logic [NUM_BOOTHS-1:0]         booth_req,
  input  logic [NUM_BOOTHS*VOTER_W-1:0] booth_voter_id,
  input  logic [NUM_BOOTHS*CAND_W-1:0]  booth_candidate,
  output logic [NUM_BOOTHS-1:0]         booth_ack,
  output logic [NUM_BOOTHS-1:0]         booth_reject,
  output logic                          polls_open,
  output logic                          result_valid,
  output logic [CAND_W-1:0]             winner,
  output logic [CNT_W-1:0]              winner_votes,
  output logic                          tie,
  output logic [CNT_W-1:0]              total_votes
`ifdef EVM_REJECT_CODE_EN
  ,
  output logic [2*NUM_BOOTHS-1:0]       booth_reject_code
`endif
);

  localparam int PTR_W      = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int NUM_VOTERS = 2 ** VOTER_W;
  localparam logic [PTR_W-1:0]  LAST_BOOTH = PTR_W'(NUM_BOOTHS - 1);
  localparam logic [CAND_W-1:0] LAST_CAND  = CAND_W'(NUM_CAND - 1);
  localparam logic [CAND_W:0]   CAND_LIMIT = (CAND_W + 1)'(NUM_CAND);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_TALLY,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_BOOTHS-1:0]   mask_q, mask_d;
  logic [NUM_BOOTHS-1:0]   ack_q, ack_d;
  logic [NUM_BOOTHS-1:0]   rej_q, rej_d;
  logic [NUM_VOTERS-1:0]   voted_q, voted_d;
  logic [CNT_W-1:0]        tally_q [NUM_CAND];
  logic [CNT_W-1:0]        tally_d [NUM_CAND];
  logic [CNT_W-1:0]        total_q, total_d;
  logic [CAND_W-1:0]       scan_q, scan_d;
  logic [CAND_W-1:0]       winner_q, winner_d;
  logic [CNT_W-1:0]        win_votes_q, win_votes_d;
  logic                    tie_q, tie_d;
  logic                    polls_open_q, polls_open_d;
  logic                    valid_q, valid_d;
`ifdef EVM_REJECT_CODE_EN
  logic [2*NUM_BOOTHS-1:0] code_q, code_d;
`endif

  logic [NUM_BOOTHS-1:0]   elig;
  logic                    hi_hit, lo_hit, gnt_vld;
  logic [PTR_W-1:0]        hi_idx, lo_idx, gnt_idx;
  logic [NUM_BOOTHS-1:0]   gnt_oh;
  logic [VOTER_W-1:0]      sel_voter;
  logic [CAND_W-1:0]       sel_cand;
  logic                    is_open, cand_ok, dup, accept, reject;
  logic [CNT_W-1:0]        scan_val;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    // Round robin: prefer the lowest eligible booth at or above ptr_q, else wrap to the lowest overall.
    elig   = booth_req & ~mask_q;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NUM_BOOTHS - 1; j >= 0; j--) begin
      if (elig[j]) begin
        lo_hit = 1'b1;
        lo_idx = PTR_W'(j);
        if (PTR_W'(j) >= ptr_q) begin
          hi_hit = 1'b1;
          hi_idx = PTR_W'(j);
        end
      end
    end
    gnt_vld = lo_hit;
    gnt_idx = hi_hit ? hi_idx : lo_idx;

    gnt_oh    = '0;
    sel_voter = '0;
    sel_cand  = '0;
    for (int j = 0; j < NUM_BOOTHS; j++) begin
      if (gnt_vld && (gnt_idx == PTR_W'(j))) begin
        gnt_oh[j] = 1'b1;
        sel_voter = booth_voter_id[j*VOTER_W +: VOTER_W];
        sel_cand  = booth_candidate[j*CAND_W +: CAND_W];
      end
    end

    is_open = (state_q == S_OPEN) && !close_polls;
    cand_ok = {1'b0, sel_cand} < CAND_LIMIT;
    dup     = voted_q[sel_voter];
    accept  = gnt_vld && is_open && cand_ok && !dup;
    reject  = gnt_vld && !accept;

    ack_d  = accept ? gnt_oh : '0;
    rej_d  = reject ? gnt_oh : '0;
    mask_d = gnt_oh;
    ptr_d  = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == LAST_BOOTH) ? '0 : gnt_idx + PTR_W'(1);
    end

`ifdef EVM_REJECT_CODE_EN
    code_d = '0;
    for (int j = 0; j < NUM_BOOTHS; j++) begin
      if (reject && gnt_oh[j]) begin
        code_d[2*j +: 2] = !is_open ? 2'b11 : (!cand_ok ? 2'b10 : 2'b01);
      end
    end
`endif

    scan_val = '0;
    for (int c = 0; c < NUM_CAND; c++) begin
      if (CAND_W'(c) == scan_q) scan_val = tally_q[c];
    end

    state_d     = state_q;
    voted_d     = voted_q;
    tally_d     = tally_q;
    total_d     = total_q;
    scan_d      = scan_q;
    winner_d    = winner_q;
    win_votes_d = win_votes_q;
    tie_d       = tie_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (open_polls) begin
          state_d     = S_OPEN;
          voted_d     = '0;
          tally_d     = '{default: '0};
          total_d     = '0;
          winner_d    = '0;
          win_votes_d = '0;
          tie_d       = 1'b0;
        end
      end
      S_OPEN: begin
        if (close_polls) begin
          state_d = S_TALLY;
          scan_d  = '0;
        end
      end
      S_TALLY: begin
        if (scan_q == '0) begin
          winner_d    = '0;
          win_votes_d = scan_val;
          tie_d       = 1'b0;
        end else if (scan_val > win_votes_q) begin
          winner_d    = scan_q;
          win_votes_d = scan_val;
          tie_d       = 1'b0;
        end else if (scan_val == win_votes_q) begin
          tie_d = 1'b1;
        end
        if (scan_q == LAST_CAND) state_d = S_DONE;
        else                     scan_d  = scan_q + CAND_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Votes are only accepted in OPEN, where no session clear can be pending.
    if (accept) begin
      voted_d[sel_voter] = 1'b1;
      for (int c = 0; c < NUM_CAND; c++) begin
        if ((CAND_W'(c) == sel_cand) && (tally_q[c] != '1)) tally_d[c] = tally_q[c] + CNT_W'(1);
      end
      if (total_q != '1) total_d = total_q + CNT_W'(1);
    end

    polls_open_d = (state_d == S_OPEN);
    valid_d      = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      mask_q       <= '0;
      ack_q        <= '0;
      rej_q        <= '0;
      // NOTE: tallies and the voted bitmap are plain flops, so they can be (and must be) cleared by reset.
      voted_q      <= '0;
      tally_q      <= '{default: '0};
      total_q      <= '0;
      scan_q       <= '0;
      winner_q     <= '0;
      win_votes_q  <= '0;
      tie_q        <= 1'b0;
      polls_open_q <= 1'b0;
      valid_q      <= 1'b0;
`ifdef EVM_REJECT_CODE_EN
      code_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      ack_q        <= ack_d;
      rej_q        <= rej_d;
      voted_q      <= voted_d;
      tally_q      <= tally_d;
      total_q      <= total_d;
      scan_q       <= scan_d;
      winner_q     <= winner_d;
      win_votes_q  <= win_votes_d;
      tie_q        <= tie_d;
      polls_open_q <= polls_open_d;
      valid_q      <= valid_d;
`ifdef EVM_REJECT_CODE_EN
      code_q       <= code_d;
`endif
    end
  end

  assign booth_ack    = ack_q;
  assign booth_reject = rej_q;
  assign polls_open   = polls_open_q;
  assign result_valid = valid_q;
  assign winner       = winner_q;
  assign winner_votes = win_votes_q;
  assign tie          = tie_q;
  assign total_votes  = total_q;
`ifdef EVM_REJECT_CODE_EN
  assign booth_reject_code = code_q;
`endif

endmodule
